speck_enc_ctrl: RTL and testbench

- Iterative SPECK32/64 encryption controller.
- Captures plaintext and key on a start handshake, then runs one round per clock through a single shared round datapath, computing each round key on the fly.
- Presents the ciphertext with a one-cycle done pulse.
- Sits above the gate-level adder/XOR/rotate primitives and sequences them.

---
 rtl/speck_enc_ctrl.sv | 142 ++++++++++++++
 tb/tb_speck_enc_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/speck_enc_ctrl.sv
// Iterative SPECK32/64 encryptor: one round per clock, round keys generated alongside the data rounds.
// Latency ROUNDS+1 cycles from accepted start to the done pulse; start is ignored while busy (ready low).
module speck_enc_ctrl #(
  parameter int WORD   = 16,
  parameter int ROUNDS = 22,
  parameter int ALPHA  = 7,
  parameter int BETA   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [2*WORD-1:0]   pt,
  input  logic [4*WORD-1:0]   key,
  output logic                ready,
  output logic                busy,
  output logic                done,
  output logic [2*WORD-1:0]   ct
);

  localparam int CW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            accept;
  logic            last;

  logic [WORD-1:0] x;
  logic [WORD-1:0] y;
  logic [WORD-1:0] k;
  logic [WORD-1:0] l0;
  logic [WORD-1:0] l1;
  logic [WORD-1:0] l2;
  logic [CW-1:0]   rnd;

  logic [WORD-1:0] x_nxt;
  logic [WORD-1:0] y_nxt;
  logic [WORD-1:0] k_nxt;
  logic [WORD-1:0] l_new;

  function automatic logic [WORD-1:0] ror_a(input logic [WORD-1:0] v);
    return (v >> ALPHA) | (v << (WORD - ALPHA));
  endfunction

  function automatic logic [WORD-1:0] rol_b(input logic [WORD-1:0] v);
    return (v << BETA) | (v >> (WORD - BETA));
  endfunction

  assign last = (rnd == CW'(ROUNDS - 1));

  // Shared round datapath: the data round consumes the current k while the
  // key schedule prepares the next one from the same k and the l-queue head.
  always_comb begin
    x_nxt = (ror_a(x) + y) ^ k;
    y_nxt = rol_b(y) ^ x_nxt;
    l_new = (k + ror_a(l0)) ^ WORD'(rnd);
    k_nxt = rol_b(k) ^ l_new;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    busy      = 1'b0;
    ready     = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy  = 1'b1;
        ready = 1'b0;
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        // A start here chains straight into the next run with no idle gap.
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x   <= '0;
      y   <= '0;
      k   <= '0;
      l0  <= '0;
      l1  <= '0;
      l2  <= '0;
      rnd <= '0;
      ct  <= '0;
    end else if (accept) begin
      x   <= pt[2*WORD-1:WORD];
      y   <= pt[WORD-1:0];
      k   <= key[WORD-1:0];
      l0  <= key[2*WORD-1:WORD];
      l1  <= key[3*WORD-1:2*WORD];
      l2  <= key[4*WORD-1:3*WORD];
      rnd <= '0;
    end else if (state == RUN) begin
      x   <= x_nxt;
      y   <= y_nxt;
      k   <= k_nxt;
      l0  <= l1;
      l1  <= l2;
      l2  <= l_new;
      // Counter parks at zero after the last round so it never wraps past ROUNDS.
      rnd <= last ? '0 : rnd + CW'(1);
      if (last) begin
        ct <= {x_nxt, y_nxt};
      end
    end
  end

endmodule

// File: tb/tb_speck_enc_ctrl.sv
// Directed bench for speck_enc_ctrl: known-answer runs, back-to-back starts,
// ignored starts while busy, mid-run reset and result hold between runs.
module tb_speck_enc_ctrl;

  localparam logic [31:0] KAT_PT  = 32'h6574_694c;
  localparam logic [63:0] KAT_KEY = 64'h1918_1110_0908_0100;
  localparam logic [31:0] KAT_CT  = 32'ha868_42f2;
  localparam logic [31:0] ALT_PT  = 32'h1234_5678;
  localparam logic [63:0] ALT_KEY = 64'h0f0e_0d0c_0b0a_0908;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] pt;
  logic [63:0] key;
  logic        ready;
  logic        busy;
  logic        done;
  logic [31:0] ct;

  int n_chk  = 0;
  int n_fail = 0;

  speck_enc_ctrl dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .pt    (pt),
    .key   (key),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .ct    (ct)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ror16(input logic [15:0] v, input int s);
    return (v >> s) | (v << (16 - s));
  endfunction

  function automatic logic [15:0] rol16(input logic [15:0] v, input int s);
    return (v << s) | (v >> (16 - s));
  endfunction

  // Reference SPECK32/64: full key expansion first, then the 22 data rounds.
  function automatic logic [31:0] speck_model(input logic [31:0] p, input logic [63:0] kk);
    logic [15:0] rk [0:21];
    logic [15:0] lw [0:23];
    logic [15:0] xm;
    logic [15:0] ym;
    rk[0] = kk[15:0];
    lw[0] = kk[31:16];
    lw[1] = kk[47:32];
    lw[2] = kk[63:48];
    for (int i = 0; i < 21; i++) begin
      lw[i+3] = (rk[i] + ror16(lw[i], 7)) ^ 16'(i);
      rk[i+1] = rol16(rk[i], 2) ^ lw[i+3];
    end
    xm = p[31:16];
    ym = p[15:0];
    for (int i = 0; i < 22; i++) begin
      xm = (ror16(xm, 7) + ym) ^ rk[i];
      ym = rol16(ym, 2) ^ xm;
    end
    return {xm, ym};
  endfunction

  // Issues one start, then watches cycles 1..win after the accepting edge.
  // Optional: stray starts with zeroed inputs in [g_lo,g_hi], reset pulse at rst_at.
  task automatic do_run(input logic [31:0] p, input logic [63:0] kk, input int win,
                        input int g_lo, input int g_hi, input int rst_at,
                        input logic [31:0] ct_prev,
                        output int dcyc, output int bcnt, output int nd,
                        output logic [31:0] cv, output int hold_bad);
    pt    = p;
    key   = kk;
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    dcyc     = 0;
    bcnt     = 0;
    nd       = 0;
    cv       = '0;
    hold_bad = 0;
    for (int c = 1; c <= win; c++) begin
      if (busy) bcnt++;
      if (done) begin
        nd++;
        if (dcyc == 0) begin
          dcyc = c;
          cv   = ct;
        end
      end else if (dcyc == 0 && rst_at == 0 && ct !== ct_prev) begin
        hold_bad++;
      end
      if (rst_at != 0 && c == rst_at + 1) begin
        check("rst_mid_ready", ready, 1);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        check("rst_mid_ct", ct, 0);
        rst = 1'b0;
      end
      if (rst_at != 0 && c == rst_at) rst = 1'b1;
      if (c >= g_lo && c <= g_hi) begin
        start = 1'b1;
        pt    = '0;
        key   = '0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int          dcyc;
    int          bcnt;
    int          nd;
    int          hb;
    int          idle_cnt;
    int          bad;
    int          dpos [0:2];
    logic [31:0] dct  [0:2];
    logic [31:0] cv;
    logic [31:0] alt_ct;

    rst   = 1'b1;
    start = 1'b0;
    pt    = '0;
    key   = '0;
    repeat (3) @(negedge clk);
    check("reset_ready", ready, 1);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_ct", ct, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single known-answer run.
    do_run(KAT_PT, KAT_KEY, 40, 0, -1, 0, 32'h0, dcyc, bcnt, nd, cv, hb);
    check("kat_done_cycle", dcyc, 23);
    check("kat_busy_cycles", bcnt, 22);
    check("kat_done_count", nd, 1);
    check("kat_ct", cv, KAT_CT);
    check("kat_ct_hold", hb, 0);

    // Start held high: three chained runs, no idle cycle between them.
    pt       = KAT_PT;
    key      = KAT_KEY;
    start    = 1'b1;
    @(negedge clk);
    nd       = 0;
    idle_cnt = 0;
    for (int c = 1; c <= 69; c++) begin
      if (ready && !done) idle_cnt++;
      if (done) begin
        if (nd < 3) begin
          dpos[nd] = c;
          dct[nd]  = ct;
        end
        nd++;
      end
      if (c == 69) start = 1'b0;
      @(negedge clk);
    end
    check("b2b_done_count", nd, 3);
    check("b2b_done_pos0", dpos[0], 23);
    check("b2b_done_pos1", dpos[1], 46);
    check("b2b_done_pos2", dpos[2], 69);
    check("b2b_ct0", dct[0], KAT_CT);
    check("b2b_ct1", dct[1], KAT_CT);
    check("b2b_ct2", dct[2], KAT_CT);
    check("b2b_idle_cycles", idle_cnt, 0);
    check("b2b_end_ready", ready, 1);
    check("b2b_end_busy", busy, 0);

    // Starts and zeroed inputs during RUN must be ignored.
    do_run(KAT_PT, KAT_KEY, 50, 5, 10, 0, KAT_CT, dcyc, bcnt, nd, cv, hb);
    check("ign_done_cycle", dcyc, 23);
    check("ign_done_count", nd, 1);
    check("ign_ct", cv, KAT_CT);
    check("ign_ct_hold", hb, 0);

    // Reset at cycle 10 aborts the run with no done pulse.
    do_run(KAT_PT, KAT_KEY, 40, 0, -1, 10, KAT_CT, dcyc, bcnt, nd, cv, hb);
    check("rst_mid_no_done", nd, 0);
    check("rst_mid_ct_after", ct, 0);

    // Fresh run after the abort.
    do_run(KAT_PT, KAT_KEY, 40, 0, -1, 0, 32'h0, dcyc, bcnt, nd, cv, hb);
    check("fresh_done_cycle", dcyc, 23);
    check("fresh_ct", cv, KAT_CT);
    check("fresh_ct_hold", hb, 0);

    // Reset release with start low for 50 cycles.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      if (ready !== 1'b1 || done !== 1'b0 || ct !== 32'h0) bad++;
      @(negedge clk);
    end
    check("release_bad_cycles", bad, 0);
    check("release_ready", ready, 1);
    check("release_ct", ct, 0);

    // Different key, then back to the known-answer key.
    alt_ct = speck_model(ALT_PT, ALT_KEY);
    do_run(ALT_PT, ALT_KEY, 40, 0, -1, 0, 32'h0, dcyc, bcnt, nd, cv, hb);
    check("alt_done_cycle", dcyc, 23);
    check("alt_ct", cv, alt_ct);
    do_run(KAT_PT, KAT_KEY, 40, 0, -1, 0, alt_ct, dcyc, bcnt, nd, cv, hb);
    check("kat2_ct_hold_alt", hb, 0);
    check("kat2_done_cycle", dcyc, 23);
    check("kat2_ct", cv, KAT_CT);
    check("kat2_ct_final", ct, KAT_CT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
